// File: rtl/fm_ctrl_pkg.sv
// Shared types and default timing constants for the FM distance controller.
package fm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fm_state_e;

    localparam int DEF_STEP          = 8;
    localparam int DEF_TICK_DIV      = 50000;
    localparam int DEF_TIMEOUT_TICKS = 250;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fm_dist_scheduler_tick_gen.sv
// Free-running tick generator: one-cycle tick every TICK_DIV clk cycles after reset release.
module tick_gen
    import fm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fm_dist_scheduler.sv
// Slews the FM DAC distance toward the latest accepted sample and drains it to zero
// when samples stop or mute is requested.
//   state    | meaning
//   ST_IDLE  | DAC disabled, distance held at 0, waiting for a sample
//   ST_RUN   | DAC enabled, distance ramps toward target on each tick
//   ST_DRAIN | DAC enabled, distance ramps toward 0; reaching 0 returns to IDLE
module fm_dist_scheduler
    import fm_ctrl_pkg::*;
#(
    parameter int WIDTH         = 13,
    parameter int MAX_DIST      = 2000,
    parameter int STEP          = DEF_STEP,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_dist,
    output logic             sample_ready,
    input  logic             mute,
    output logic             fm_enable,
    output logic [WIDTH-1:0] fm_distance,
    output logic [1:0]       state_out,
    output logic             sat_pulse
);

    localparam int TW = cnt_width(TIMEOUT_TICKS + 1);
    localparam logic [WIDTH-1:0]        MAX_D   = WIDTH'(MAX_DIST);
    localparam logic [WIDTH-1:0]        STEP_U  = WIDTH'(STEP);
    localparam logic signed [WIDTH:0]   STEP_S  = (WIDTH+1)'(STEP);
    localparam logic [TW-1:0]           TO_LAST = TW'(TIMEOUT_TICKS);

    fm_state_e        state_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] dist_q;
    logic             en_q;
    logic             sat_q;
    logic [TW-1:0]    to_q;

    logic                    tick;
    logic                    accept;
    logic                    over;
    logic [WIDTH-1:0]        clamped;
    logic signed [WIDTH:0]   diff;
    logic [WIDTH-1:0]        ramp_d;
    logic [WIDTH-1:0]        drain_d;
    logic [TW-1:0]           to_d;
    logic                    expire;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign sample_ready = !mute;
    assign accept       = sample_valid && !mute;
    assign over         = (sample_dist > MAX_D);
    assign clamped      = over ? MAX_D : sample_dist;
    assign to_d         = to_q + TW'(1);
    assign expire       = (to_d >= TO_LAST);

    // Signed difference keeps the ramp from overshooting or wrapping in either direction.
    always_comb begin
        diff    = $signed({1'b0, target_q}) - $signed({1'b0, dist_q});
        ramp_d  = target_q;
        if (diff > STEP_S) begin
            ramp_d = dist_q + STEP_U;
        end else if (diff < -STEP_S) begin
            ramp_d = dist_q - STEP_U;
        end
        drain_d = (dist_q > STEP_U) ? dist_q - STEP_U : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            dist_q   <= '0;
            en_q     <= 1'b0;
            sat_q    <= 1'b0;
            to_q     <= '0;
        end else begin
            sat_q <= accept && over;
            case (state_q)
                ST_IDLE: begin
                    en_q   <= 1'b0;
                    dist_q <= '0;
                    to_q   <= '0;
                    if (accept) begin
                        target_q <= clamped;
                        dist_q   <= clamped;
                        en_q     <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    en_q <= 1'b1;
                    // The step always uses the target held before this edge.
                    if (tick) begin
                        dist_q <= ramp_d;
                    end
                    if (accept) begin
                        target_q <= clamped;
                        to_q     <= '0;
                    end else if (mute) begin
                        state_q <= ST_DRAIN;
                    end else if (tick) begin
                        to_q <= to_d;
                        if (expire) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    en_q <= 1'b1;
                    if (tick) begin
                        dist_q <= drain_d;
                    end
                    if (accept) begin
                        target_q <= clamped;
                        to_q     <= '0;
                        state_q  <= ST_RUN;
                    end else if (tick && (dist_q == '0)) begin
                        en_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    target_q <= '0;
                    dist_q   <= '0;
                    en_q     <= 1'b0;
                    to_q     <= '0;
                end
            endcase
        end
    end

    assign fm_enable   = en_q;
    assign fm_distance = dist_q;
    assign state_out   = state_q;
    assign sat_pulse   = sat_q;

endmodule

// File: tb/tb_fm_dist_scheduler.sv
// Directed bench for fm_dist_scheduler with TICK_DIV=4, STEP=8, TIMEOUT_TICKS=3, MAX_DIST=2000.
module tb_fm_dist_scheduler;

    logic        clk;
    logic        reset_n;
    logic        sample_valid;
    logic [12:0] sample_dist;
    logic        sample_ready;
    logic        mute;
    logic        fm_enable;
    logic [12:0] fm_distance;
    logic [1:0]  state_out;
    logic        sat_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int peak  = 0;

    fm_dist_scheduler #(
        .WIDTH         (13),
        .MAX_DIST      (2000),
        .STEP          (8),
        .TICK_DIV      (4),
        .TIMEOUT_TICKS (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_dist  (sample_dist),
        .sample_ready (sample_ready),
        .mute         (mute),
        .fm_enable    (fm_enable),
        .fm_distance  (fm_distance),
        .state_out    (state_out),
        .sat_pulse    (sat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ticks land on edges where cyc%4==0; optional feed lands on a non-tick edge.
    task automatic next_tick(input bit feed, input logic [12:0] v);
        do begin
            sample_valid = feed && (((cyc + 1) % 4) == 2);
            sample_dist  = v;
            step();
        end while ((cyc % 4) != 0);
        sample_valid = 1'b0;
    endtask

    task automatic accept_at_non_tick(input logic [12:0] v);
        if (((cyc + 1) % 4) == 0) step();
        sample_valid = 1'b1;
        sample_dist  = v;
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_dist  = '0;
        mute         = 1'b0;
        step();
        step();
        chk("rst_state", state_out, 0);
        chk("rst_en", fm_enable, 0);
        chk("rst_dist", fm_distance, 0);
        chk("rst_sat", sat_pulse, 0);
        chk("rst_ready", sample_ready, 1);
        mute = 1'b1;
        #1;
        chk("rst_ready_mute", sample_ready, 0);
        mute = 1'b0;
        step();
        reset_n = 1'b1;
        cyc = 0;

        step();
        step();
        chk("idle_hold", state_out, 0);

        sample_valid = 1'b1;
        sample_dist  = 13'd100;
        step();
        chk("acc100_en", fm_enable, 1);
        chk("acc100_dist", fm_distance, 100);
        chk("acc100_state", state_out, 1);
        chk("acc100_sat", sat_pulse, 0);

        // Acceptance coincides with a tick: step uses old target 100.
        sample_dist = 13'd125;
        step();
        sample_valid = 1'b0;
        chk("tick_acc_pre_target", fm_distance, 100);
        next_tick(1'b1, 13'd125);
        chk("ramp_108", fm_distance, 108);
        next_tick(1'b1, 13'd125);
        chk("ramp_116", fm_distance, 116);
        next_tick(1'b1, 13'd125);
        chk("ramp_124", fm_distance, 124);
        next_tick(1'b1, 13'd125);
        chk("ramp_125", fm_distance, 125);
        next_tick(1'b1, 13'd125);
        chk("hold_125", fm_distance, 125);
        chk("hold_state", state_out, 1);

        sample_valid = 1'b1;
        sample_dist  = 13'd3000;
        step();
        sample_valid = 1'b0;
        chk("sat_pulse_hi", sat_pulse, 1);
        chk("sat_dist_unchanged", fm_distance, 125);
        step();
        chk("sat_pulse_lo", sat_pulse, 0);
        for (int i = 0; i < 240; i++) begin
            next_tick(1'b1, 13'd3000);
            if (int'(fm_distance) > peak) peak = int'(fm_distance);
        end
        chk("clamp_peak", peak, 2000);
        chk("clamp_final", fm_distance, 2000);

        accept_at_non_tick(13'd500);
        next_tick(1'b1, 13'd500);
        chk("down_1992", fm_distance, 1992);
        next_tick(1'b1, 13'd500);
        chk("down_1984", fm_distance, 1984);
        reset_n = 1'b0;
        #2;
        chk("async_rst_state", state_out, 0);
        chk("async_rst_en", fm_enable, 0);
        chk("async_rst_dist", fm_distance, 0);
        chk("async_rst_sat", sat_pulse, 0);
        step();
        reset_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) step();
        chk("post_rst_state", state_out, 0);
        chk("post_rst_dist", fm_distance, 0);
        chk("post_rst_en", fm_enable, 0);

        accept_at_non_tick(13'd20);
        chk("acc20_state", state_out, 1);
        chk("acc20_dist", fm_distance, 20);
        next_tick(1'b0, 13'd0);
        chk("to1_state", state_out, 1);
        next_tick(1'b0, 13'd0);
        chk("to2_state", state_out, 1);
        next_tick(1'b0, 13'd0);
        chk("to3_drain", state_out, 2);
        chk("to3_dist", fm_distance, 20);
        next_tick(1'b0, 13'd0);
        chk("drain_12", fm_distance, 12);
        next_tick(1'b0, 13'd0);
        chk("drain_4", fm_distance, 4);
        next_tick(1'b0, 13'd0);
        chk("drain_0", fm_distance, 0);
        chk("drain_0_en", fm_enable, 1);
        chk("drain_0_state", state_out, 2);
        next_tick(1'b0, 13'd0);
        chk("drain_idle_state", state_out, 0);
        chk("drain_idle_en", fm_enable, 0);

        mute         = 1'b1;
        sample_valid = 1'b1;
        sample_dist  = 13'd77;
        step();
        chk("idle_mute_state", state_out, 0);
        chk("idle_mute_en", fm_enable, 0);
        mute         = 1'b0;
        sample_valid = 1'b0;

        accept_at_non_tick(13'd40);
        chk("acc40_dist", fm_distance, 40);
        chk("acc40_state", state_out, 1);
        if (((cyc + 1) % 4) == 0) step();
        mute         = 1'b1;
        sample_valid = 1'b1;
        sample_dist  = 13'd77;
        #1;
        chk("mute_ready", sample_ready, 0);
        step();
        chk("mute_drain_state", state_out, 2);
        chk("mute_dist", fm_distance, 40);
        mute         = 1'b0;
        sample_valid = 1'b0;
        next_tick(1'b0, 13'd0);
        chk("mute_drain_32", fm_distance, 32);
        accept_at_non_tick(13'd50);
        chk("drain_acc_state", state_out, 1);
        chk("drain_acc_dist", fm_distance, 32);
        next_tick(1'b0, 13'd0);
        chk("rerun_40", fm_distance, 40);
        chk("rerun_state", state_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fm_dist_scheduler.md
FM_DIST_SCHEDULER -- requirements
Module: fm_dist_scheduler

Interface
REQ-001 Parameters SHALL be as follows (one per line: name, default, meaning):
  WIDTH, 13, bit width of distance values
  MAX_DIST, 2000, largest distance passed to the FM DAC; larger samples are clamped to this value
  STEP, 8, largest change in fm_distance per tick
  TICK_DIV, 50000, clk cycles per update tick (1 kHz at 50 MHz)
  TIMEOUT_TICKS, 250, ticks without an accepted sample before draining starts
REQ-002 Ports SHALL be as follows (one per line: name, direction, width, meaning):
  clk  in  1  system clock
  reset_n  in  1  reset, asynchronous, active-low
  sample_valid  in  1  sample_dist is valid
  sample_dist  in  WIDTH  new target distance
  sample_ready  out  1  block accepts a sample this cycle
  mute  in  1  request to silence output
  fm_enable  out  1  enable to the FM DAC
  fm_distance  out  WIDTH  distance to the FM DAC
  state_out  out  2  current state (IDLE=0, RUN=1, DRAIN=2)
  sat_pulse  out  1  one-cycle pulse when an accepted sample is clamped

Function
REQ-003 A sample SHALL be accepted on a rising clk edge when sample_valid and sample_ready are both 1; sample_ready SHALL equal !mute.
REQ-004 An accepted sample SHALL be clamped to MAX_DIST; sat_pulse SHALL be 1 for exactly the next cycle when sample_dist > MAX_DIST.
REQ-005 Tick SHALL be a one-cycle pulse every TICK_DIV cycles from a free-running counter that starts at reset release and is unaffected by state.
REQ-006 IDLE: fm_enable=0, fm_distance=0; an accepted sample SHALL load target and fm_distance with the clamped value and enter RUN, with fm_enable=1 one cycle after acceptance.
REQ-007 RUN: fm_enable=1; on each tick fm_distance SHALL move toward target by min(STEP, |target-fm_distance|), with no overshoot; an accepted sample SHALL update target only.
REQ-008 A tick and an acceptance in the same cycle: the step SHALL use the pre-update target, and the new target SHALL take effect from the next tick.
REQ-009 The timeout counter SHALL clear on every acceptance and increment on every tick in RUN; reaching TIMEOUT_TICKS, or mute=1, SHALL move RUN to DRAIN; an acceptance in the same cycle as the expiring tick SHALL cancel the transition.
REQ-010 DRAIN: fm_enable=1; each tick SHALL decrease fm_distance by min(STEP, fm_distance); an accepted sample SHALL set target and return to RUN; fm_distance==0 on a tick SHALL enter IDLE with fm_enable=0 on the following cycle.
REQ-011 mute=1 in IDLE SHALL keep the block in IDLE; mute=1 SHALL override any sample_valid.
REQ-012 Step arithmetic SHALL use WIDTH+1-bit signed differences; fm_distance SHALL never exceed MAX_DIST or wrap below 0.
REQ-013 Illegal state encodings SHALL return to IDLE on the next clk edge.

Reset
REQ-014 While reset_n=0: state=IDLE, fm_enable=0, fm_distance=0, target=0, timeout and tick counters=0, sat_pulse=0, sample_ready=!mute.
REQ-015 Reset asserted mid-RUN or mid-DRAIN SHALL take effect immediately (asynchronous) and drop all pending targets.

Structure
REQ-016 The state enum typedef and the default values of STEP, TICK_DIV and TIMEOUT_TICKS SHALL reside in the shared package fm_ctrl_pkg.
REQ-017 Tick generation SHALL be a sub-module tick_gen (parameter TICK_DIV, output tick); all remaining logic is one FSM plus datapath.

Verification (bench parameters: TICK_DIV=4, STEP=8, TIMEOUT_TICKS=3, MAX_DIST=2000)
REQ-018 From IDLE, accept 100 -> next cycle fm_enable=1, fm_distance=100, state_out=1.
REQ-019 In RUN at 100, accept 125 -> successive ticks give 108, 116, 124, 125, then hold at 125.
REQ-020 Accept 3000 -> target 2000 and sat_pulse high for exactly one cycle; fm_distance never exceeds 2000.
REQ-021 At 20 with no samples for 3 ticks -> DRAIN; distance 12, 4, 0; then IDLE with fm_enable=0.
REQ-022 In RUN assert mute with sample_valid=1 -> sample_ready=0, sample ignored, DRAIN entered next cycle; accept 50 in DRAIN after releasing mute -> RUN.
REQ-023 Assert reset_n=0 mid-ramp -> all outputs are at reset values within the same cycle; after release, IDLE is held until the next sample.
